mem_image_loader: RTL and testbench

MEM_IMAGE_LOADER -- requirements
Module: mem_image_loader

---
 rtl/mem_image_loader_pkg.sv | 16 +
 rtl/mem_readback_checker.sv | 55 +++++
 rtl/mem_image_loader.sv | 107 ++++++++++
 tb/tb_mem_image_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_image_loader_pkg.sv
// Shared definitions for the memory image loader: default geometry and the
// load sequencer state encoding.
package mem_image_loader_pkg;

  localparam int REG_WIDTH_DEF = 8;
  localparam int MEM_DEPTH_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } load_state_e;

endpackage

// File: rtl/mem_readback_checker.sv
// Compares RAM read data one cycle after each accepted read against the
// source image, counting mismatches and latching the first failing address.
module mem_readback_checker
  import mem_image_loader_pkg::*;
#(
  parameter  int REG_WIDTH  = REG_WIDTH_DEF,
  parameter  int MEM_DEPTH  = MEM_DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_clear,
  input  logic                           i_rd_accept,
  input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
  input  logic [REG_WIDTH*MEM_DEPTH-1:0] i_image_flat,
  input  logic [REG_WIDTH-1:0]           i_rdata,
  output logic [ADDR_WIDTH:0]            o_err_count,
  output logic [ADDR_WIDTH-1:0]          o_first_err_addr
);

  localparam logic [ADDR_WIDTH:0] ERR_MAX = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic                  r_pend_valid;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic [ADDR_WIDTH:0]   r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic [REG_WIDTH-1:0]  w_expected;
  logic                  w_mismatch;

  assign w_expected = i_image_flat[int'(r_pend_addr)*REG_WIDTH +: REG_WIDTH];
  assign w_mismatch = r_pend_valid && (i_rdata != w_expected);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_pend_valid     <= 1'b0;
      r_pend_addr      <= '0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else begin
      r_pend_valid <= i_rd_accept;
      if (i_rd_accept) r_pend_addr <= i_rd_addr;
      if (w_mismatch) begin
        if (r_err_count != ERR_MAX) r_err_count <= r_err_count + 1'b1;
        // A zero count means no earlier mismatch in this load.
        if (r_err_count == '0) r_first_err_addr <= r_pend_addr;
      end
    end
  end

  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: rtl/mem_image_loader.sv
// Copies a flat image into a RAM, reads it back for verification, and holds
// the CPU stalled for the duration of the load.
module mem_image_loader
  import mem_image_loader_pkg::*;
#(
  parameter  int REG_WIDTH  = REG_WIDTH_DEF,
  parameter  int MEM_DEPTH  = MEM_DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load_req,
  input  logic [REG_WIDTH*MEM_DEPTH-1:0] image_flat,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [REG_WIDTH-1:0]           mem_wdata,
  input  logic                           mem_ready,
  input  logic [REG_WIDTH-1:0]           mem_rdata,
  output logic                           cpu_hold,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH:0]            err_count,
  output logic [ADDR_WIDTH-1:0]          first_err_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  load_state_e           r_state, w_state_nxt;
  logic                  r_load_q;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [REG_WIDTH-1:0]  r_wdata;
  logic                  w_rise, w_accept, w_last, w_clear, w_rd_accept;

  assign w_rise      = load_req && !r_load_q;
  assign w_accept    = mem_en && mem_ready;
  assign w_last      = (r_addr == LAST_ADDR);
  assign w_clear     = w_rise && ((r_state == IDLE) || (r_state == DONE));
  assign w_rd_accept = (r_state == READ) && w_accept;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    unique case (r_state)
      IDLE, DONE: if (w_rise) begin
        w_state_nxt = WRITE;
        w_addr_nxt  = '0;
      end
      WRITE: if (w_accept) begin
        if (w_last) begin
          w_state_nxt = READ;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
        end
      end
      // The final read keeps its address so mem_addr holds once idle.
      READ: if (w_accept) begin
        if (w_last) w_state_nxt = DRAIN;
        else        w_addr_nxt  = r_addr + 1'b1;
      end
      DRAIN:   w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_load_q <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_load_q <= load_req;
      r_addr   <= w_addr_nxt;
      if (w_state_nxt == WRITE)
        r_wdata <= image_flat[int'(w_addr_nxt)*REG_WIDTH +: REG_WIDTH];
    end
  end

  assign mem_en    = (r_state == WRITE) || (r_state == READ);
  assign mem_we    = (r_state == WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state == WRITE) || (r_state == READ) || (r_state == DRAIN);
  assign cpu_hold  = busy;
  assign done      = (r_state == DONE);

  mem_readback_checker #(
    .REG_WIDTH (REG_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_checker (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_clear          (w_clear),
    .i_rd_accept      (w_rd_accept),
    .i_rd_addr        (r_addr),
    .i_image_flat     (image_flat),
    .i_rdata          (mem_rdata),
    .o_err_count      (err_count),
    .o_first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_mem_image_loader.sv
// Self-checking bench: RAM model with access logging and fault injection,
// reference expectations derived from the image and the corruption set.
module tb_mem_image_loader;

  localparam int RW = 8;
  localparam int MD = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n, load_req, mem_en, mem_we, mem_ready;
  logic          cpu_hold, busy, done;
  logic [AW-1:0] mem_addr, first_err_addr;
  logic [RW-1:0] mem_wdata;
  logic [RW-1:0] mem_rdata = '0;
  logic [AW:0]   err_count;
  logic [RW*MD-1:0] image_flat;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] img [MD];
  logic [RW-1:0] ram [MD];
  bit            corrupt [MD];
  bit            ready_rand = 1'b0;

  int            wr_addr_q [$];
  logic [RW-1:0] wr_data_q [$];
  int            rd_addr_q [$];

  mem_image_loader dut (
    .clk(clk), .reset_n(reset_n), .load_req(load_req), .image_flat(image_flat),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) mem_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;

  // RAM model: logs every accepted access; reads return data one cycle later.
  always @(posedge clk) begin
    if (mem_en && mem_ready) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_addr_q.push_back(int'(mem_addr));
        wr_data_q.push_back(mem_wdata);
      end else begin
        mem_rdata <= corrupt[mem_addr] ? ~ram[mem_addr] : ram[mem_addr];
        rd_addr_q.push_back(int'(mem_addr));
      end
    end
  end

  // Number of deviations from "every address written with its word, then
  // every address read, each exactly once and in ascending order".
  function automatic int log_errors();
    int n = 0;
    if (wr_addr_q.size() != MD) n++;
    if (rd_addr_q.size() != MD) n++;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (i >= MD || wr_addr_q[i] != i || wr_data_q[i] !== img[i]) n++;
    for (int i = 0; i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] != i) n++;
    return n;
  endfunction

  function automatic int exp_err();
    int n = 0;
    for (int i = 0; i < MD; i++) if (corrupt[i]) n++;
    return (n > MD) ? MD : n;
  endfunction

  function automatic int exp_first();
    for (int i = 0; i < MD; i++) if (corrupt[i]) return i;
    return 0;
  endfunction

  task automatic set_image(input bit random_words);
    for (int j = 0; j < MD; j++) begin
      img[j] = random_words ? RW'($urandom) : (RW'(j) ^ 8'hA5);
      image_flat[j*RW +: RW] = img[j];
    end
  endtask

  task automatic clear_corrupt();
    for (int j = 0; j < MD; j++) corrupt[j] = 1'b0;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  // Waits for done (bounded); cycles counts from the first busy sample.
  task automatic wait_done(output int cycles, output bit ok);
    cycles = -1;
    ok     = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      load_req = 1'b0;
      if (busy && cycles < 0) cycles = 0;
      else if (cycles >= 0)   cycles++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_load(output int cycles, output bit ok);
    clear_logs();
    @(negedge clk);
    load_req = 1'b1;
    wait_done(cycles, ok);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({mem_en, mem_we, busy, done, cpu_hold} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {mem_en, mem_we, busy, done, cpu_hold});
    end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_bus: got addr %0h wdata %0h expected 0 0", mem_addr, mem_wdata);
    end
    checks++; if (err_count !== '0 || first_err_addr !== '0) begin
      errors++; $display("FAIL reset_err: got cnt %0d first %0h expected 0 0", err_count, first_err_addr);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_start: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int cycles; bit ok;
    ready_rand = 1'b0;
    set_image(1'b0);
    clear_corrupt();
    run_load(cycles, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++; if (cycles != 2*MD + 1) begin
      errors++; $display("FAIL basic_cycles: got %0d expected %0d", cycles, 2*MD + 1);
    end
    checks++; if (log_errors() != 0) begin
      errors++; $display("FAIL basic_access_log: got %0d deviations expected 0", log_errors());
    end
    checks++; if (err_count !== (AW+1)'(exp_err())) begin
      errors++; $display("FAIL basic_err_count: got %0d expected %0d", err_count, exp_err());
    end
    checks++; if ({busy, cpu_hold, mem_en} !== 3'b000) begin
      errors++; $display("FAIL basic_idle_flags: got %b expected 000", {busy, cpu_hold, mem_en});
    end
    checks++; if (mem_addr !== AW'(MD-1) || mem_wdata !== img[MD-1]) begin
      errors++; $display("FAIL basic_hold: got addr %0h wdata %0h expected %0h %0h", mem_addr, mem_wdata, MD-1, img[MD-1]);
    end
  endtask

  task automatic test_corrupt();
    int cycles; bit ok;
    ready_rand = 1'b0;
    set_image(1'b1);
    clear_corrupt();
    corrupt[8'h3C] = 1'b1;
    corrupt[8'h80] = 1'b1;
    run_load(cycles, ok);
    checks++; if (!ok || err_count !== (AW+1)'(exp_err())) begin
      errors++; $display("FAIL corrupt_err_count: got %0d expected %0d", err_count, exp_err());
    end
    checks++; if (first_err_addr !== AW'(exp_first())) begin
      errors++; $display("FAIL corrupt_first_addr: got %0h expected %0h", first_err_addr, exp_first());
    end
  endtask

  task automatic test_random_ready();
    int cycles; bit ok;
    ready_rand = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      set_image(1'b1);
      clear_corrupt();
      if (pass == 1) for (int k = 0; k < 5; k++) corrupt[$urandom_range(8, MD-1)] = 1'b1;
      run_load(cycles, ok);
      checks++; if (!ok || log_errors() != 0) begin
        errors++; $display("FAIL rand_access_log pass %0d: got %0d deviations ok %b expected 0", pass, log_errors(), ok);
      end
      checks++; if (err_count !== (AW+1)'(exp_err()) || first_err_addr !== AW'(exp_first())) begin
        errors++; $display("FAIL rand_errors pass %0d: got %0d/%0h expected %0d/%0h",
                           pass, err_count, first_err_addr, exp_err(), exp_first());
      end
    end
    ready_rand = 1'b0;
  endtask

  task automatic test_saturation();
    int cycles; bit ok;
    set_image(1'b1);
    for (int j = 0; j < MD; j++) corrupt[j] = 1'b1;
    run_load(cycles, ok);
    checks++; if (!ok || err_count !== (AW+1)'(MD) || first_err_addr !== '0) begin
      errors++; $display("FAIL saturate: got %0d/%0h expected %0d/0", err_count, first_err_addr, MD);
    end
    clear_corrupt();
  endtask

  task automatic test_reset_mid_load();
    int cycles; bit ok; bit hit;
    set_image(1'b1);
    clear_logs();
    @(negedge clk);
    load_req = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      load_req = 1'b0;
      if (mem_en && mem_we && mem_addr == 8'h40) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midreset_reach: got no write at 40 expected one"); end
    reset_n  = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    checks++; if ({mem_en, busy, cpu_hold} !== 3'b000) begin
      errors++; $display("FAIL midreset_abort: got en/busy/hold %b expected 000", {mem_en, busy, cpu_hold});
    end
    clear_logs();
    reset_n = 1'b1;
    wait_done(cycles, ok);
    checks++; if (!ok || cycles != 2*MD + 1) begin
      errors++; $display("FAIL midreset_restart_cycles: got %0d ok %b expected %0d", cycles, ok, 2*MD + 1);
    end
    checks++; if (log_errors() != 0 || err_count !== '0) begin
      errors++; $display("FAIL midreset_restart_log: got %0d deviations err %0d expected 0 0", log_errors(), err_count);
    end
  endtask

  task automatic test_retrigger();
    int cycles; bit ok; bit hit; int busy_seen;
    set_image(1'b1);
    clear_logs();
    @(negedge clk);
    load_req = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      load_req = 1'b0;
      if (mem_en && !mem_we && mem_addr == 8'h10) begin hit = 1'b1; break; end
    end
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    load_req = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    checks++; if (!hit || !ok) begin
      errors++; $display("FAIL retrig_done: got hit %b done %b expected 1 1", hit, ok);
    end
    checks++; if (log_errors() != 0 || err_count !== '0) begin
      errors++; $display("FAIL retrig_single_pass: got %0d deviations err %0d expected 0 0", log_errors(), err_count);
    end
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || !done) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin
      errors++; $display("FAIL retrig_held_high: got %0d restarted cycles expected 0", busy_seen);
    end
    load_req = 1'b0;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    checks++; if (!busy || !mem_we || mem_addr !== '0 || done) begin
      errors++; $display("FAIL retrig_restart: got busy %b we %b addr %0h done %b expected 1 1 0 0", busy, mem_we, mem_addr, done);
    end
    wait_done(cycles, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retrig_second_done: got no done expected done"); end
  endtask

  initial begin
    reset_n   = 1'b0;
    load_req  = 1'b0;
    mem_ready = 1'b1;
    clear_corrupt();
    set_image(1'b0);
    test_reset();
    test_basic();
    test_corrupt();
    test_random_ready();
    test_saturation();
    test_reset_mid_load();
    test_retrigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
